// File: rtl/fft_sched_pkg.sv
// Shared state encoding and default frame/timeout constants for the spectrum
// display frame scheduler, the FFT core and the LCD draw controller.
package fft_sched_pkg;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_CAPTURE    = 4'd1,
        S_FFT_START  = 4'd2,
        S_FFT_WAIT   = 4'd3,
        S_DRAW_START = 4'd4,
        S_DRAW_WAIT  = 4'd5,
        S_HOLD       = 4'd6
    } sched_state_e;

    localparam int unsigned DEF_N_SAMPLES   = 1024;
    localparam int unsigned DEF_ADDR_W      = 10;
    localparam int unsigned DEF_FFT_TIMEOUT = 65535;
    localparam int unsigned DEF_HOLDOFF     = 100000;
    localparam int unsigned DEF_CNT_W       = 32;

endpackage

// File: rtl/fft_sched_timer.sv
// Clear/enable cycle counter with a terminal-count flag, shared between the
// FFT timeout guard and the inter-frame hold-off.
module fft_sched_timer
    import fft_sched_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority over enable
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High during the limit-th counted cycle; a zero limit never terminates
    assign tc_o = (limit_i != '0) && (cnt_q == (limit_i - CNT_W'(1)));

endmodule

// File: rtl/fft_frame_scheduler.sv
// Frame sequencer: captures N_SAMPLES into the FFT buffer, kicks the FFT,
// then the LCD plotter, with an FFT timeout guard and an inter-frame hold-off.
module fft_frame_scheduler
    import fft_sched_pkg::*;
#(
    parameter int unsigned N_SAMPLES   = DEF_N_SAMPLES,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned FFT_TIMEOUT = DEF_FFT_TIMEOUT,
    parameter int unsigned HOLDOFF     = DEF_HOLDOFF,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ad_valid_i,
    input  logic [7:0]        ad_data_i,
    input  logic              run_i,
    input  logic              single_i,
    input  logic              err_clr_i,
    input  logic              fft_over_i,
    input  logic              lcd_draw_over_i,
    output logic              buf_wr_en_o,
    output logic [ADDR_W-1:0] buf_wr_addr_o,
    output logic [7:0]        buf_wr_data_o,
    output logic              fft_start_o,
    output logic              lcd_draw_start_o,
    output logic              busy_o,
    output logic              fft_timeout_err_o,
    output logic [15:0]       frame_cnt_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0]  FFT_LIMIT = CNT_W'(FFT_TIMEOUT);
    localparam logic [CNT_W-1:0]  HOLD_LIMIT = CNT_W'(HOLDOFF);

    sched_state_e      state_q, state_d;
    logic              single_pend_q, single_pend_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              err_q, err_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              buf_wr_en_q;
    logic [ADDR_W-1:0] buf_wr_addr_q;
    logic [7:0]        buf_wr_data_q;
    logic              fft_start_q, draw_start_q, busy_q;
    logic              wr_en_s;
    logic              tmr_clr_s, tmr_en_s, tmr_tc_s;
    logic [CNT_W-1:0]  tmr_limit_s;

    fft_sched_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (tmr_clr_s),
        .en_i    (tmr_en_s),
        .limit_i (tmr_limit_s),
        .tc_o    (tmr_tc_s)
    );

    assign wr_en_s = (state_q == S_CAPTURE) && ad_valid_i;

    // Next-state, counters and timer control; the timer stays cleared outside FFT_WAIT/HOLD
    always_comb begin
        state_d       = state_q;
        single_pend_d = single_pend_q | single_i;
        idx_d         = idx_q;
        frame_cnt_d   = frame_cnt_q;
        tmr_clr_s     = 1'b1;
        tmr_en_s      = 1'b0;
        tmr_limit_s   = FFT_LIMIT;
        if (err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (run_i || single_pend_q) begin
                    state_d       = S_CAPTURE;
                    single_pend_d = single_i;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CAPTURE: begin
                if (ad_valid_i) begin
                    idx_d = idx_q + ADDR_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FFT_START;
                    end else begin
                        state_d = S_CAPTURE;
                    end
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_FFT_START: begin
                state_d = S_FFT_WAIT;
            end
            S_FFT_WAIT: begin
                tmr_clr_s = 1'b0;
                if (fft_over_i) begin
                    state_d = S_DRAW_START;
                end else if (tmr_tc_s) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d  = S_FFT_WAIT;
                    tmr_en_s = 1'b1;
                end
            end
            S_DRAW_START: begin
                state_d = S_DRAW_WAIT;
            end
            S_DRAW_WAIT: begin
                if (lcd_draw_over_i) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    if (HOLDOFF == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                    end
                end else begin
                    state_d = S_DRAW_WAIT;
                end
            end
            S_HOLD: begin
                tmr_clr_s   = 1'b0;
                tmr_en_s    = 1'b1;
                tmr_limit_s = HOLD_LIMIT;
                if (tmr_tc_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; strobes decode the upcoming state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            single_pend_q <= 1'b0;
            idx_q         <= '0;
            err_q         <= 1'b0;
            frame_cnt_q   <= 16'd0;
            buf_wr_en_q   <= 1'b0;
            buf_wr_addr_q <= '0;
            buf_wr_data_q <= 8'd0;
            fft_start_q   <= 1'b0;
            draw_start_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            single_pend_q <= single_pend_d;
            idx_q         <= idx_d;
            err_q         <= err_d;
            frame_cnt_q   <= frame_cnt_d;
            buf_wr_en_q   <= wr_en_s;
            if (wr_en_s) begin
                buf_wr_addr_q <= idx_q;
                buf_wr_data_q <= ad_data_i;
            end
            fft_start_q   <= (state_d == S_FFT_START);
            draw_start_q  <= (state_d == S_DRAW_START);
            busy_q        <= (state_d != S_IDLE);
        end
    end

    assign buf_wr_en_o       = buf_wr_en_q;
    assign buf_wr_addr_o     = buf_wr_addr_q;
    assign buf_wr_data_o     = buf_wr_data_q;
    assign fft_start_o       = fft_start_q;
    assign lcd_draw_start_o  = draw_start_q;
    assign busy_o            = busy_q;
    assign fft_timeout_err_o = err_q;
    assign frame_cnt_o       = frame_cnt_q;

endmodule
